// File: rtl/code_driver.sv
// Command sequencer for the code counter block: snapshots a counter, pulses En
// a programmed number of cycles, then checks the counter advanced by exactly that much.
module code_driver #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CmdValid,
    input  logic             CmdSlt,
    input  logic [CNT_W-1:0] CmdCount,
    output logic             CmdReady,
    output logic             Slt,
    output logic             En,
    input  logic [63:0]      Output0,
    input  logic [63:0]      Output1,
    output logic             Done,
    output logic             Err,
    output logic [63:0]      Result,
    output logic [2:0]       o_dbg_state
);

    // Handshake: a command transfers on a rising edge where CmdValid=1 and
    // CmdReady=1; CmdReady is high only in IDLE, so commands offered while busy
    // are simply not taken and leave every latched field untouched.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SNAP   = 3'd1,
        S_DRIVE  = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_slt;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_expected;
    logic [63:0]      r_result;
    logic             r_err;
    logic             w_accept;
    logic [63:0]      w_sel_out;

    assign w_accept  = CmdValid && (r_state == S_IDLE);
    assign w_sel_out = r_slt ? Output1 : Output0;

    always_comb begin
        w_next   = r_state;
        CmdReady = 1'b0;
        En       = 1'b0;
        Done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) w_next = S_SNAP;
            end
            S_SNAP: begin
                w_next = (r_cnt != '0) ? S_DRIVE : S_SETTLE;
            end
            S_DRIVE: begin
                En = 1'b1;
                if (r_cnt == CNT_W'(1)) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                w_next = S_CHECK;
            end
            S_CHECK: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_slt      <= 1'b0;
            r_cnt      <= '0;
            r_expected <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_slt <= CmdSlt;
                r_cnt <= CmdCount;
                r_err <= 1'b0;
            end
            // Base is folded straight into Expected; the sum wraps modulo 2^64.
            if (r_state == S_SNAP) begin
                r_expected <= w_sel_out + 64'(r_cnt);
            end
            if (r_state == S_DRIVE) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_state == S_CHECK) begin
                r_result <= w_sel_out;
                r_err    <= (w_sel_out != r_expected);
            end
        end
    end

    assign Slt         = r_slt;
    assign Err         = r_err;
    assign Result      = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_code_driver.sv
// Bench for code_driver: a behavioural code-counter block plus directed and
// randomized commands checked against start-value + applied-count arithmetic.
module tb_code_driver;

    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             CmdValid;
    logic             CmdSlt;
    logic [CNT_W-1:0] CmdCount;
    logic             CmdReady;
    logic             Slt;
    logic             En;
    logic [63:0]      Output0;
    logic [63:0]      Output1;
    logic             Done;
    logic             Err;
    logic [63:0]      Result;
    logic [2:0]       dbg_state;

    code_driver #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdSlt(CmdSlt),
        .CmdCount(CmdCount), .CmdReady(CmdReady), .Slt(Slt), .En(En),
        .Output0(Output0), .Output1(Output1), .Done(Done), .Err(Err),
        .Result(Result), .o_dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    // Code counter block: selected counter advances on each En cycle, registered.
    logic [63:0] cnt0 = '0;
    logic [63:0] cnt1 = '0;
    logic [63:0] ofs0 = '0;
    logic [63:0] ofs1 = '0;
    bit          stall0 = 1'b0;

    always @(posedge Clk) begin
        if (En === 1'b1) begin
            if (Slt) cnt1 <= cnt1 + 64'd1;
            else if (!stall0) cnt0 <= cnt0 + 64'd1;
        end
    end

    assign Output0 = ofs0 + cnt0;
    assign Output1 = ofs1 + cnt1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_result = '0;
    logic        last_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge Clk);
            check("idle_en", En, 1'b0);
            check("idle_done", Done, 1'b0);
            check("idle_ready", CmdReady, 1'b1);
            check("idle_err_hold", Err, last_err);
            check("idle_result_hold", Result, last_result);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns at the Done negedge.
    // With hold=1 CmdValid stays high and the next command's fields are presented
    // while this one is still busy.
    task automatic do_cmd(input logic slt, input logic [CNT_W-1:0] n, input bit hold,
                          input logic nslt, input logic [CNT_W-1:0] nn);
        logic [63:0] start;
        logic [63:0] incs;
        int          nn_i;
        nn_i = int'(n);
        CmdValid = 1'b1;
        CmdSlt   = slt;
        CmdCount = n;
        check("ready_at_issue", CmdReady, 1'b1);
        start = slt ? Output1 : Output0;
        incs  = (!slt && stall0) ? 64'd0 : 64'(n);
        @(posedge Clk);
        for (int k = 1; k <= nn_i + 4; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                if (hold) begin
                    CmdSlt   = nslt;
                    CmdCount = nn;
                end else begin
                    CmdValid = 1'b0;
                end
            end
            check("en_window", En, (k >= 2 && k <= nn_i + 1));
            check("slt_busy", Slt, slt);
            check("ready_busy", CmdReady, 1'b0);
            check("done_timing", Done, (k == nn_i + 4));
        end
        last_result = start + incs;
        last_err    = (incs != 64'(n));
        check("result", Result, last_result);
        check("err", Err, last_err);
    endtask

    initial begin
        logic             r_slt_a;
        logic             r_slt_b;
        logic [CNT_W-1:0] r_n_a;
        logic [CNT_W-1:0] r_n_b;
        bit               r_hold;

        Reset    = 1'b1;
        CmdValid = 1'b0;
        CmdSlt   = 1'b0;
        CmdCount = '0;
        repeat (3) @(negedge Clk);
        check("rst_en", En, 1'b0);
        check("rst_slt", Slt, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_err", Err, 1'b0);
        check("rst_result", Result, 64'd0);
        check("rst_ready", CmdReady, 1'b1);
        check("rst_state_idle", dbg_state, 3'd0);
        Reset = 1'b0;
        idle(2);

        // Five En pulses on counter 0 starting from zero
        do_cmd(1'b0, CNT_W'(5), 1'b0, 1'b0, '0);
        check("basic_result_5", Result, 64'd5);
        idle(3);

        // Zero count: no En, counter 1 returned unchanged
        do_cmd(1'b1, CNT_W'(0), 1'b0, 1'b0, '0);
        idle(2);

        // Expected wraps past 2^64
        ofs1 = 64'hFFFF_FFFF_FFFF_FFFE - cnt1;
        idle(1);
        do_cmd(1'b1, CNT_W'(3), 1'b0, 1'b0, '0);
        check("wrap_result", Result, 64'd1);
        check("wrap_err", Err, 1'b0);
        idle(2);

        // Counter 0 ignores En: mismatch flagged, Result is the unchanged base
        stall0 = 1'b1;
        ofs0   = 64'h0000_1234_5678_9ABC - cnt0;
        idle(1);
        do_cmd(1'b0, CNT_W'(4), 1'b0, 1'b0, '0);
        check("stall_err", Err, 1'b1);
        check("stall_result", Result, 64'h0000_1234_5678_9ABC);
        stall0 = 1'b0;
        idle(3);

        // Full-scale count
        do_cmd(1'b1, {CNT_W{1'b1}}, 1'b0, 1'b0, '0);
        idle(2);

        // CmdValid held across a busy command: next one taken one cycle after Done
        do_cmd(1'b0, CNT_W'(3), 1'b1, 1'b1, CNT_W'(6));
        @(negedge Clk);
        do_cmd(1'b1, CNT_W'(6), 1'b0, 1'b0, '0);
        idle(4);

        // Randomized commands, sometimes chained back-to-back
        repeat (12) begin
            if ($urandom_range(0, 2) == 0) begin
                ofs0 = {$urandom, $urandom};
                ofs1 = {$urandom, $urandom};
                idle(1);
            end
            stall0  = ($urandom_range(0, 3) == 0);
            r_slt_a = 1'($urandom_range(0, 1));
            r_slt_b = 1'($urandom_range(0, 1));
            r_n_a   = CNT_W'($urandom_range(0, 20));
            r_n_b   = CNT_W'($urandom_range(0, 20));
            r_hold  = ($urandom_range(0, 2) == 0);
            do_cmd(r_slt_a, r_n_a, r_hold, r_slt_b, r_n_b);
            if (r_hold) begin
                @(negedge Clk);
                do_cmd(r_slt_b, r_n_b, 1'b0, 1'b0, '0);
            end
            idle($urandom_range(1, 3));
        end
        stall0 = 1'b0;

        // Reset on the second DRIVE cycle aborts the command
        CmdValid = 1'b1;
        CmdSlt   = 1'b1;
        CmdCount = CNT_W'(10);
        check("abort_ready_at_issue", CmdReady, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        CmdValid = 1'b0;
        @(negedge Clk);
        check("abort_drive1_en", En, 1'b1);
        @(negedge Clk);
        check("abort_drive2_en", En, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_en", En, 1'b0);
        check("abort_done", Done, 1'b0);
        check("abort_ready", CmdReady, 1'b1);
        check("abort_slt", Slt, 1'b0);
        check("abort_result", Result, 64'd0);
        check("abort_err", Err, 1'b0);
        last_result = '0;
        last_err    = 1'b0;
        idle(15);

        // Recovery after abort
        do_cmd(1'b0, CNT_W'(2), 1'b0, 1'b0, '0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
